// File: rtl/alert_uart_tx.sv
// Alert link transmitter: sends {seq, hb, final, cam, fft} framed behind a sync byte as 8N1 UART.
// Optional ALERT_TX_CHECKSUM_EN appends byte2 = byte0 ^ byte1 to every frame.
module alert_uart_tx #(
  parameter int          CLKS_PER_BIT     = 434,
  parameter int          HEARTBEAT_CYCLES = 50000000,
  parameter logic [7:0]  SYNC_BYTE        = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fft_flag_in,
  input  logic       cam_flag_in,
  input  logic       final_alert_in,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done,
  output logic [3:0] seq_out,
  output logic [1:0] dbg_state_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HB_W  = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEAT_CYCLES - 1);
`ifdef ALERT_TX_CHECKSUM_EN
  localparam logic [1:0] LAST_BYTE = 2'd2;
`else
  localparam logic [1:0] LAST_BYTE = 2'd1;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [1:0]       byte_idx_q;
  logic [7:0]       shift_q;
  logic [3:0]       flags_q;
  logic [3:0]       seq_q;
  logic [2:0]       last_sent_q;
  logic [HB_W-1:0]  hb_cnt_q, hb_cnt_d;
  logic             hb_pending_q, hb_pending_d;
  logic             tx_q, busy_q, done_q;

  logic [2:0] status;
  logic       status_changed;
  logic       trigger;
  logic [7:0] byte1;
  logic [7:0] next_byte;

  always_comb begin
    status         = {final_alert_in, cam_flag_in, fft_flag_in};
    status_changed = (status != last_sent_q);
    trigger        = (state_q == IDLE) && (status_changed || hb_pending_q);
    byte1          = {seq_q, flags_q};
    // next_byte is the byte that follows the one currently on the line
    next_byte      = byte1;
`ifdef ALERT_TX_CHECKSUM_EN
    if (byte_idx_q == 2'd1) next_byte = SYNC_BYTE ^ byte1;
`endif
    hb_cnt_d     = hb_cnt_q + 1'b1;
    hb_pending_d = hb_pending_q;
    if (trigger) begin
      hb_cnt_d     = '0;
      hb_pending_d = 1'b0;
    end else if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d     = '0;
      hb_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      flags_q      <= '0;
      seq_q        <= '0;
      last_sent_q  <= '0;
      hb_cnt_q     <= '0;
      hb_pending_q <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      hb_cnt_q     <= hb_cnt_d;
      hb_pending_q <= hb_pending_d;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (trigger) begin
            // hb flag only when nothing but the heartbeat asked for this frame
            flags_q     <= {hb_pending_q & ~status_changed, status};
            last_sent_q <= status;
            shift_q     <= SYNC_BYTE;
            byte_idx_q  <= '0;
            bit_cnt_q   <= '0;
            tx_q        <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_q <= '0;
            if (byte_idx_q == LAST_BYTE) begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              seq_q   <= seq_q + 1'b1;
              state_q <= IDLE;
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
              shift_q    <= next_byte;
              tx_q       <= 1'b0;
              state_q    <= START;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_out      = tx_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign seq_out     = seq_q;
  assign dbg_state_o = state_q;

endmodule
